amber128_regfile_mp: RTL and testbench
======================================

// Module: amber128_regfile_mp
// PURPOSE
// - Multi-port data register file for the amber128 core. Generalises the single-write/dual-read file.
// - Parametrised read and write port counts.
// - Per-register pending scoreboard: issue sets a register's pending bit, writeback clears it.
// - Optional same-cycle write-to-read bypass.
// - Sits between decode/issue (reads, scoreboard) and the writeback stage(s).
// PARAMETERS
// - XLEN      128  data width per register
// - REGS      32   number of registers; register 0 is hard zero
// - NRD       3    read ports
// - NWR       2    write ports; higher index = younger writer
// - AW        $clog2(REGS)  address width (derived, localparam)
// PORTS
// - clk_i       in   1          clock
// - rst_ni      in   1          reset: synchronous, active-low
// - flush_i     in   1          clear all pending bits
// - rd_addr_i   in   NRD*AW     read addresses
// - rd_data_o   out  NRD*XLEN   read data
// - rd_busy_o   out  NRD        read register pending (written by an in-flight op)
// - wr_valid_i  in   NWR        write strobes
// - wr_addr_i   in   NWR*AW     write addresses
// - wr_data_i   in   NWR*XLEN   write data
// - iss_valid_i in   1          issue: mark iss_addr_i pending
// - iss_addr_i  in   AW         destination register being issued
// - conflict_o  out  1          two+ valid writes to the same nonzero register this cycle
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge): all registers <= 0, all pending <= 0.
//   - Reset overrides writes, issue and flush in the same cycle.
//   - Outputs during/after reset: rd_data_o=0, rd_busy_o=0, conflict_o=0.
// - Writes: registered at posedge when wr_valid_i[k] and wr_addr_i[k]!=0.
//   - Writes to register 0 are dropped.
//   - Same-address multi-write: highest port index wins.
//   - conflict_o=1 combinationally in that cycle; write is still performed. Diagnostic only.
// - Reads: combinational, zero-latency.
//   - Address 0 always returns 0 and busy=0.
//   - Out-of-range address (>=REGS, REGS not power of 2) returns 0, busy=0.
// - Scoreboard (pending[REGS], sequential). Next-state priority, highest first:
//   1. rst_ni=0 -> all 0
//   2. flush_i -> all 0; a same-cycle issue is also discarded
//   3. iss_valid_i & iss_addr_i!=0 -> pending[iss_addr_i]=1; issue beats a same-cycle writeback to that register
//   4. wr_valid_i[k] & wr_addr_i[k]!=0 -> pending[wr_addr_i[k]]=0
// - Issue to register 0: ignored.
// - Re-issue to an already-pending register: stays 1. No counting; a single writeback clears it.
// - rd_busy_o[j] = pending[rd_addr_i[j]], registered state only, without bypass. Ignores same-cycle writes.
// - All data paths are full XLEN; no truncation or extension.
// CONFIGURATION
// - Macro AMBER128_RF_BYPASS_EN.
// - Defined: write-to-read bypass.
//   - If any wr_valid_i[k] matches rd_addr_i[j] (nonzero), rd_data_o[j] = wr_data_i of the highest matching k in the same cycle.
//   - rd_busy_o[j] is forced to 0 in that case, unless iss_valid_i targets the same register in that cycle.
// - Undefined: reads return stored contents only; new data is visible the cycle after the write.
//   - rd_busy_o as listed under BEHAVIOUR.
// TESTING
// - Reset: write r5=0xA5 then hold rst_ni=0 for 1 cycle -> r5 reads 0, all rd_busy_o=0.
// - Zero register: wr port0 r0=0xFFFF, issue r0 -> read r0 = 0, busy 0.
// - Conflict: port0 and port1 both write r7 (0x11, 0x22) -> conflict_o=1 that cycle; next cycle r7=0x22.
// - Scoreboard: issue r3 -> busy(r3)=1 next cycle.
//   - Issue r3 plus wb r3 in the same cycle -> still 1.
//   - wb r3 alone -> 0 next cycle.
//   - Issue r4 plus flush -> busy(r4)=0.
// - Bypass: write r9=0x1234 while reading r9 (old value 0).
//   - With AMBER128_RF_BYPASS_EN: same-cycle read=0x1234, busy=0.
//   - Without: read=0, then 0x1234 next cycle.
// - Multi-read: read r1,r1,r2 on ports 0-2 after writes r1=1, r2=2 -> outputs 1,1,2.

Source files
------------

// File: rtl/amber128_regfile_mp_if.sv
// amber128 multi-port register file bus: read ports, write ports, issue/scoreboard
// and diagnostics. Clock and reset are kept as plain module ports.
interface amber128_regfile_mp_if #(
    parameter int XLEN = 128,
    parameter int REGS = 32,
    parameter int NRD  = 3,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(REGS);

    logic                flush_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NWR-1:0]      wr_valid_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic                iss_valid_i;
    logic [AW-1:0]       iss_addr_i;
    logic                conflict_o;

    // Issue/writeback side: drives addresses, data and strobes.
    modport master (
        output flush_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               iss_valid_i, iss_addr_i,
        input  rd_data_o, rd_busy_o, conflict_o
    );

    // Register file side.
    modport slave (
        input  flush_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               iss_valid_i, iss_addr_i,
        output rd_data_o, rd_busy_o, conflict_o
    );
endinterface

// File: rtl/amber128_regfile_mp.sv
// amber128 multi-port data register file with per-register pending scoreboard.
// Register 0 reads as zero and ignores writes/issues. Higher write port index is
// the younger writer and wins on same-address writes.
// Optional feature: define AMBER128_RF_BYPASS_EN for same-cycle write-to-read bypass.
module amber128_regfile_mp #(
    parameter int XLEN = 128,
    parameter int REGS = 32,
    parameter int NRD  = 3,
    parameter int NWR  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    amber128_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(REGS);

    logic [XLEN-1:0] regs_q [REGS];
    logic [XLEN-1:0] regs_d [REGS];
    logic [REGS-1:0] pend_q;
    logic [REGS-1:0] pend_d;
    logic            conflict;

    // Nonzero and inside the file (only matters when REGS is not a power of 2).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < 32'(REGS));
    endfunction

    // Write-port merge: later (higher) ports overwrite earlier ones.
    always_comb begin
        logic [AW-1:0] wa;
        wa = '0;
        for (int r = 0; r < REGS; r++) regs_d[r] = regs_q[r];
        for (int k = 0; k < NWR; k++) begin
            wa = bus.wr_addr_i[k*AW +: AW];
            if (bus.wr_valid_i[k] && addr_ok(wa)) regs_d[wa] = bus.wr_data_i[k*XLEN +: XLEN];
        end
        regs_d[0] = '0;
    end

    // Register storage with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < REGS; r++) begin
            if (!rst_ni) regs_q[r] <= '0;
            else         regs_q[r] <= regs_d[r];
        end
    end

    // Scoreboard next state: writeback clears, issue sets over it, flush clears all.
    always_comb begin
        logic [AW-1:0] wa;
        wa     = '0;
        pend_d = pend_q;
        for (int k = 0; k < NWR; k++) begin
            wa = bus.wr_addr_i[k*AW +: AW];
            if (bus.wr_valid_i[k] && addr_ok(wa)) pend_d[wa] = 1'b0;
        end
        if (bus.iss_valid_i && addr_ok(bus.iss_addr_i)) pend_d[bus.iss_addr_i] = 1'b1;
        if (bus.flush_i) pend_d = '0;
        pend_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    // Diagnostic: two or more valid writes to the same nonzero register.
    always_comb begin
        conflict = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (bus.wr_valid_i[a] && bus.wr_valid_i[b] &&
                    (bus.wr_addr_i[a*AW +: AW] == bus.wr_addr_i[b*AW +: AW]) &&
                    (bus.wr_addr_i[a*AW +: AW] != '0))
                    conflict = 1'b1;
            end
        end
        bus.conflict_o = conflict & rst_ni;
    end

    // Combinational read ports; outputs are held at zero while reset is asserted.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            busy;
`ifdef AMBER128_RF_BYPASS_EN
        logic            hit;
        hit = 1'b0;
`endif
        ra            = '0;
        data          = '0;
        busy          = 1'b0;
        bus.rd_data_o = '0;
        bus.rd_busy_o = '0;
        for (int j = 0; j < NRD; j++) begin
            ra   = bus.rd_addr_i[j*AW +: AW];
            data = '0;
            busy = 1'b0;
            if (addr_ok(ra)) begin
                data = regs_q[ra];
                busy = pend_q[ra];
            end
`ifdef AMBER128_RF_BYPASS_EN
            hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_valid_i[k] && addr_ok(ra) && (bus.wr_addr_i[k*AW +: AW] == ra)) begin
                    data = bus.wr_data_i[k*XLEN +: XLEN];
                    hit  = 1'b1;
                end
            end
            // A same-cycle issue to this register keeps it busy despite the bypass.
            if (hit && !(bus.iss_valid_i && (bus.iss_addr_i == ra))) busy = 1'b0;
`endif
            if (!rst_ni) begin
                data = '0;
                busy = 1'b0;
            end
            bus.rd_data_o[j*XLEN +: XLEN] = data;
            bus.rd_busy_o[j]              = busy;
        end
    end
endmodule

// File: tb/tb_amber128_regfile_mp.sv
// Directed table-driven bench for amber128_regfile_mp (default parameters).
module tb_amber128_regfile_mp;
    localparam int XLEN = 128;
    localparam int REGS = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;
`ifdef AMBER128_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [127:0] WIDE = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    amber128_regfile_mp_if #(.XLEN(XLEN), .REGS(REGS), .NRD(NRD), .NWR(NWR)) bus ();

    amber128_regfile_mp #(.XLEN(XLEN), .REGS(REGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          flush;
        logic [AW-1:0] ra [3];
        logic [1:0]    wv;
        logic [AW-1:0] wa [2];
        logic [127:0]  wd [2];
        logic          iv;
        logic [AW-1:0] ia;
        logic [127:0]  ed [3];
        logic [2:0]    eb;
        logic          ec;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic f,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic [1:0] wv,
                       input logic [AW-1:0] wa0, input logic [127:0] wd0,
                       input logic [AW-1:0] wa1, input logic [127:0] wd1,
                       input logic iv, input logic [AW-1:0] ia,
                       input logic [127:0] e0, input logic [127:0] e1, input logic [127:0] e2,
                       input logic [2:0] eb, input logic ec);
        vec_t v;
        v.rst_n = r;   v.flush = f;
        v.ra[0] = ra0; v.ra[1] = ra1; v.ra[2] = ra2;
        v.wv    = wv;
        v.wa[0] = wa0; v.wd[0] = wd0; v.wa[1] = wa1; v.wd[1] = wd1;
        v.iv    = iv;  v.ia = ia;
        v.ed[0] = e0;  v.ed[1] = e1;  v.ed[2] = e2;
        v.eb    = eb;  v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst_n           = v.rst_n;
        bus.flush_i     = v.flush;
        bus.rd_addr_i   = {v.ra[2], v.ra[1], v.ra[0]};
        bus.wr_valid_i  = v.wv;
        bus.wr_addr_i   = {v.wa[1], v.wa[0]};
        bus.wr_data_i   = {v.wd[1], v.wd[0]};
        bus.iss_valid_i = v.iv;
        bus.iss_addr_i  = v.ia;
    endtask

    task automatic chk(input string nm, input logic [127:0] e0, input logic [127:0] e1,
                       input logic [127:0] e2, input logic [2:0] eb, input logic ec);
        logic [127:0] ed [3];
        logic [127:0] got;
        ed[0] = e0; ed[1] = e1; ed[2] = e2;
        vectors++;
        for (int j = 0; j < NRD; j++) begin
            got = bus.rd_data_o[j*XLEN +: XLEN];
            if (got !== ed[j]) begin
                $display("FAIL %s rd_data[%0d] got %h want %h", nm, j, got, ed[j]);
                miscompares++;
            end
        end
        if (bus.rd_busy_o !== eb) begin
            $display("FAIL %s rd_busy got %b want %b", nm, bus.rd_busy_o, eb);
            miscompares++;
        end
        if (bus.conflict_o !== ec) begin
            $display("FAIL %s conflict got %b want %b", nm, bus.conflict_o, ec);
            miscompares++;
        end
    endtask

    initial begin
        vec_t idle;
        idle.rst_n = 1'b0; idle.flush = 1'b0; idle.wv = 2'b00; idle.iv = 1'b0; idle.ia = '0;
        for (int j = 0; j < 3; j++) begin idle.ra[j] = '0; idle.ed[j] = '0; end
        for (int k = 0; k < 2; k++) begin idle.wa[k] = '0; idle.wd[k] = '0; end
        idle.eb = '0; idle.ec = 1'b0;
        drive(idle);

        //  rst flush ra0 ra1 ra2  wv    wa0 wd0          wa1 wd1        iv ia  e0 e1 e2 eb ec
        add(0, 0,  0, 0, 0, 2'b00, 0, 0,          0, 0,          0, 0,  0, 0, 0, 3'b000, 0);
        add(1, 0,  5, 0, 0, 2'b01, 5, 128'hA5,    0, 0,          0, 0,  BYP ? 128'hA5 : 128'h0, 0, 0, 3'b000, 0);
        add(1, 0,  5, 0, 0, 2'b00, 0, 0,          0, 0,          0, 0,  128'hA5, 0, 0, 3'b000, 0);
        add(0, 1,  5, 5, 5, 2'b11, 5, 128'hFF,    5, 128'h66,    1, 5,  0, 0, 0, 3'b000, 0);
        add(1, 0,  5, 6, 5, 2'b00, 0, 0,          0, 0,          0, 0,  0, 0, 0, 3'b000, 0);
        add(1, 0,  0, 0, 0, 2'b11, 0, 128'hFFFF,  0, 128'h1,     1, 0,  0, 0, 0, 3'b000, 0);
        add(1, 0,  0, 0, 0, 2'b00, 0, 0,          0, 0,          0, 0,  0, 0, 0, 3'b000, 0);
        add(1, 0,  7, 0, 0, 2'b11, 7, 128'h11,    7, 128'h22,    0, 0,  BYP ? 128'h22 : 128'h0, 0, 0, 3'b000, 1);
        add(1, 0,  7, 7, 0, 2'b00, 0, 0,          0, 0,          0, 0,  128'h22, 128'h22, 0, 3'b000, 0);
        add(1, 0,  3, 0, 0, 2'b00, 0, 0,          0, 0,          1, 3,  0, 0, 0, 3'b000, 0);
        add(1, 0,  3, 0, 0, 2'b01, 3, 128'h33,    0, 0,          1, 3,  BYP ? 128'h33 : 128'h0, 0, 0, 3'b001, 0);
        add(1, 0,  3, 0, 0, 2'b10, 0, 0,          3, 128'h44,    0, 0,  BYP ? 128'h44 : 128'h33, 0, 0, {2'b00, !BYP}, 0);
        add(1, 1,  3, 4, 0, 2'b00, 0, 0,          0, 0,          1, 4,  128'h44, 0, 0, 3'b000, 0);
        add(1, 0,  3, 4, 0, 2'b00, 0, 0,          0, 0,          0, 0,  128'h44, 0, 0, 3'b000, 0);
        add(1, 0,  6, 0, 0, 2'b00, 0, 0,          0, 0,          1, 6,  0, 0, 0, 3'b000, 0);
        add(1, 0,  6, 0, 0, 2'b00, 0, 0,          0, 0,          1, 6,  0, 0, 0, 3'b001, 0);
        add(1, 0,  6, 0, 0, 2'b01, 6, 128'h6,     0, 0,          0, 0,  BYP ? 128'h6 : 128'h0, 0, 0, {2'b00, !BYP}, 0);
        add(1, 0,  6, 0, 0, 2'b00, 0, 0,          0, 0,          0, 0,  128'h6, 0, 0, 3'b000, 0);
        add(1, 0,  9, 9, 1, 2'b10, 0, 0,          9, 128'h1234,  0, 0,  BYP ? 128'h1234 : 128'h0, BYP ? 128'h1234 : 128'h0, 0, 3'b000, 0);
        add(1, 0,  9, 0, 0, 2'b11, 1, 128'h1,     2, 128'h2,     0, 0,  128'h1234, 0, 0, 3'b000, 0);
        add(1, 0,  1, 1, 2, 2'b00, 0, 0,          0, 0,          0, 0,  128'h1, 128'h1, 128'h2, 3'b000, 0);
        add(1, 0, 10, 8, 0, 2'b01, 10, WIDE,      0, 0,          1, 8,  BYP ? WIDE : 128'h0, 0, 0, 3'b000, 0);
        add(1, 1, 10, 8, 0, 2'b00, 0, 0,          0, 0,          0, 0,  WIDE, 0, 0, 3'b010, 0);
        add(1, 0, 10, 8, 0, 2'b00, 0, 0,          0, 0,          0, 0,  WIDE, 0, 0, 3'b000, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d", i), tbl[i].ed[0], tbl[i].ed[1], tbl[i].ed[2], tbl[i].eb, tbl[i].ec);
        end

        // Conflicting writes plus issue to r12, then a flush racing a writeback to r12.
        @(negedge clk);
        drive(idle);
        rst_n           = 1'b1;
        bus.rd_addr_i   = {5'd0, 5'd0, 5'd12};
        bus.wr_valid_i  = 2'b11;
        bus.wr_addr_i   = {5'd12, 5'd12};
        bus.wr_data_i   = {128'hBB, 128'hAA};
        bus.iss_valid_i = 1'b1;
        bus.iss_addr_i  = 5'd12;
        #1;
        chk("seq_conflict_issue", BYP ? 128'hBB : 128'h0, 0, 0, 3'b000, 1'b1);

        @(negedge clk);
        bus.wr_valid_i  = 2'b00;
        bus.iss_valid_i = 1'b0;
        #1;
        chk("seq_young_wins_busy", 128'hBB, 0, 0, 3'b001, 1'b0);

        @(negedge clk);
        bus.flush_i    = 1'b1;
        bus.wr_valid_i = 2'b01;
        bus.wr_addr_i  = {5'd0, 5'd12};
        bus.wr_data_i  = {128'h0, 128'hCC};
        #1;
        chk("seq_flush_wb", BYP ? 128'hCC : 128'hBB, 0, 0, {2'b00, !BYP}, 1'b0);

        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.wr_valid_i = 2'b00;
        #1;
        chk("seq_after_flush", 128'hCC, 0, 0, 3'b000, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
